// File: rtl/fb_rect_fill_if.sv
// rtl/fb_rect_fill_if.sv - fill-command handshake, vblank and framebuffer write-port bundle
interface fb_rect_fill_if #(
  parameter int ADDR_W = 19
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        cmd_x0;
  logic [9:0]        cmd_x1;
  logic [9:0]        cmd_y0;
  logic [9:0]        cmd_y1;
  logic [11:0]       cmd_color;
  logic              cmd_sync;
  logic              vblank;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_sync, vblank,
    input  cmd_ready, we, waddr, wdata, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_sync, vblank,
    output cmd_ready, we, waddr, wdata, busy, done
  );
endinterface

// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - solid-colour rectangle fill engine, one framebuffer write per clock
module fb_rect_fill #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input logic          clk,
  input logic          rstn,
  fb_rect_fill_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_VB, FILL, DONE} state_t;

  localparam logic [9:0]        X_MAX  = 10'(H_RES - 1);
  localparam logic [9:0]        Y_MAX  = 10'(V_RES - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic [9:0]        x0_q, x0_d, x1c_q, x1c_d, y1c_q, y1c_d;
  logic [11:0]       color_q, color_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [9:0] cmd_x1c, cmd_y1c;
  logic       cmd_empty;

  // Start-row base via constant shift-and-add over the set bits of the stride.
  function automatic logic [ADDR_W-1:0] row_of(input logic [9:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < ADDR_W; b++)
      if (H_RES[b]) acc = acc + ({{(ADDR_W-10){1'b0}}, y} << b);
    return acc;
  endfunction

  always_comb begin
    cmd_x1c   = (bus.cmd_x1 > X_MAX) ? X_MAX : bus.cmd_x1;
    cmd_y1c   = (bus.cmd_y1 > Y_MAX) ? Y_MAX : bus.cmd_y1;
    cmd_empty = (bus.cmd_x0 > cmd_x1c) || (bus.cmd_y0 > cmd_y1c);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    x0_d       = x0_q;
    x1c_d      = x1c_q;
    y1c_d      = y1c_q;
    color_d    = color_q;
    row_base_d = row_base_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          x0_d       = bus.cmd_x0;
          x1c_d      = cmd_x1c;
          y1c_d      = cmd_y1c;
          color_d    = bus.cmd_color;
          x_d        = bus.cmd_x0;
          y_d        = bus.cmd_y0;
          row_base_d = cmd_empty ? '0 : row_of(bus.cmd_y0);
          if (cmd_empty)                        state_d = DONE;
          else if (bus.cmd_sync && !bus.vblank) state_d = WAIT_VB;
          else                                  state_d = FILL;
        end
      end
      WAIT_VB: if (bus.vblank) state_d = FILL;
      FILL: begin
        // x_q/y_q name the pixel on the write port this cycle.
        if (x_q == x1c_q && y_q == y1c_q) begin
          state_d = DONE;
        end else if (x_q == x1c_q) begin
          x_d        = x0_q;
          y_d        = y_q + 10'd1;
          row_base_d = row_base_q + STRIDE;
        end else begin
          x_d = x_q + 10'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    we_d        = (state_d == FILL);
    waddr_d     = we_d ? row_base_d + {{(ADDR_W-10){1'b0}}, x_d} : '0;
    wdata_d     = we_d ? {4'b0000, color_d} : 16'h0000;
    done_d      = (state_d == DONE);
    cmd_ready_d = (state_d == IDLE);
    // Covers the cycle after returning to IDLE so an empty command shows busy for two cycles.
    busy_d      = (state_d != IDLE) || (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      x0_q        <= '0;
      x1c_q       <= '0;
      y1c_q       <= '0;
      color_q     <= '0;
      row_base_q  <= '0;
      cmd_ready_q <= 1'b1;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x0_q        <= x0_d;
      x1c_q       <= x1c_d;
      y1c_q       <= y1c_d;
      color_q     <= color_d;
      row_base_q  <= row_base_d;
      cmd_ready_q <= cmd_ready_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_fb_rect_fill.sv
// tb/tb_fb_rect_fill.sv - randomized and directed rectangle-fill bench against a raster reference model
module tb_fb_rect_fill;
  logic clk;
  logic rstn;
  int   total;
  int   bad;

  fb_rect_fill_if #(.ADDR_W(19)) bus ();

  fb_rect_fill #(.H_RES(640), .V_RES(480), .ADDR_W(19)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_junk();
    bus.cmd_valid = 1'b1;
    bus.cmd_x0    = 10'($urandom_range(0, 1023));
    bus.cmd_x1    = 10'($urandom_range(0, 1023));
    bus.cmd_y0    = 10'($urandom_range(0, 1023));
    bus.cmd_y1    = 10'($urandom_range(0, 1023));
    bus.cmd_color = 12'($urandom);
    bus.cmd_sync  = 1'($urandom);
  endtask

  // Issue one command, record every cycle after acceptance and compare against
  // the raster list of pixels the clipped rectangle should produce.
  task automatic run_cmd(input int x0, input int x1, input int y0, input int y1,
                         input int color, input bit sync, input int vb_low, input bit junk);
    int exp_q[$];
    int wk[$];
    int wa[$];
    int wd[$];
    int done_k, done_cnt, busy_cnt, rdy_at_done, rdy_after, amis, dmis, first_exp, limit, w;
    int xe, ye;
    xe = (x1 > 639) ? 639 : x1;
    ye = (y1 > 479) ? 479 : y1;
    for (int y = y0; y <= ye; y++)
      for (int x = x0; x <= xe; x++)
        exp_q.push_back(y * 640 + x);
    done_k = 0; done_cnt = 0; busy_cnt = 0; rdy_at_done = -1; rdy_after = -1;
    amis = 0; dmis = 0;
    first_exp = (sync && vb_low > 0) ? vb_low + 1 : 1;
    limit = exp_q.size() + vb_low + 10;

    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_cmd", bus.cmd_ready, 1);

    bus.cmd_valid = 1'b1;
    bus.cmd_x0    = 10'(x0);
    bus.cmd_x1    = 10'(x1);
    bus.cmd_y0    = 10'(y0);
    bus.cmd_y1    = 10'(y1);
    bus.cmd_color = 12'(color);
    bus.cmd_sync  = sync;
    if (sync) bus.vblank = (vb_low == 0);

    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (bus.we) begin
        wk.push_back(k);
        wa.push_back(int'(bus.waddr));
        wd.push_back(int'(bus.wdata));
      end
      busy_cnt += int'(bus.busy);
      if (bus.done) begin
        done_cnt++;
        if (done_k == 0) begin
          done_k = k;
          rdy_at_done = int'(bus.cmd_ready);
        end
      end
      if (done_k != 0 && k == done_k + 1) rdy_after = int'(bus.cmd_ready);
      if (done_k != 0 && k == done_k + 2) break;
      if (junk && done_k == 0) drive_junk();
      else bus.cmd_valid = 1'b0;
      if (sync) begin
        if (k == vb_low) bus.vblank = 1'b1;
        if (k == vb_low + 4) bus.vblank = 1'b0;
      end else begin
        bus.vblank = 1'($urandom);
      end
    end
    bus.cmd_valid = 1'b0;

    check("done_seen", done_k != 0, 1);
    check("write_count", wa.size(), exp_q.size());
    for (int i = 0; i < wa.size() && i < exp_q.size(); i++) begin
      if (wa[i] != exp_q[i]) amis++;
      if (wd[i] != (color & 12'hfff)) dmis++;
    end
    check("addr_seq_errs", amis, 0);
    check("wdata_errs", dmis, 0);
    if (exp_q.size() > 0 && wk.size() > 0) begin
      check("first_write_cyc", wk[0], first_exp);
      check("last_addr", wa[wa.size()-1], exp_q[exp_q.size()-1]);
      check("contiguous", wk[wk.size()-1] - wk[0] + 1, wk.size());
      check("done_cyc", done_k, wk[wk.size()-1] + 1);
    end else begin
      check("empty_done_cyc", done_k, 1);
      check("empty_busy_cycles", busy_cnt, 2);
    end
    check("done_pulses", done_cnt, 1);
    check("ready_at_done", rdy_at_done, 0);
    check("ready_after_done", rdy_after, 1);
    check("busy_cycles", busy_cnt, done_k + 1);
  endtask

  initial begin
    int wcnt;
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0 = '0; bus.cmd_x1 = '0; bus.cmd_y0 = '0; bus.cmd_y1 = '0;
    bus.cmd_color = '0; bus.cmd_sync = 1'b0; bus.vblank = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_we", bus.we, 0);
    check("rst_waddr", bus.waddr, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_cmd(5, 5, 7, 7, 12'hF00, 1'b0, 0, 1'b0);
    run_cmd(638, 639, 478, 479, 12'h0A5, 1'b0, 0, 1'b0);
    run_cmd(630, 700, 0, 0, 12'h123, 1'b0, 0, 1'b0);
    run_cmd(0, 3, 470, 600, 12'hFFF, 1'b0, 0, 1'b0);
    run_cmd(10, 5, 0, 0, 12'h456, 1'b0, 0, 1'b0);
    run_cmd(700, 710, 0, 0, 12'h789, 1'b0, 0, 1'b0);
    run_cmd(3, 8, 100, 101, 12'h321, 1'b1, 5, 1'b0);
    run_cmd(20, 39, 10, 12, 12'hABC, 1'b1, 20, 1'b0);
    run_cmd(1, 4, 2, 3, 12'h0F0, 1'b1, 0, 1'b1);
    run_cmd(100, 105, 200, 200, 12'h00F, 1'b0, 0, 1'b1);

    for (int n = 0; n < 25; n++) begin
      int rx0, ry0;
      rx0 = $urandom_range(0, 700);
      ry0 = $urandom_range(0, 500);
      run_cmd(rx0, rx0 + $urandom_range(0, 14) - 2, ry0, ry0 + $urandom_range(0, 5) - 1,
              $urandom_range(0, 4095), 1'($urandom), $urandom_range(0, 8), 1'($urandom));
    end

    // Reset partway through a 100x100 fill.
    bus.cmd_valid = 1'b1;
    bus.cmd_x0 = 10'd0; bus.cmd_x1 = 10'd99; bus.cmd_y0 = 10'd0; bus.cmd_y1 = 10'd99;
    bus.cmd_color = 12'h555; bus.cmd_sync = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (50) @(negedge clk);
    check("pre_rst_we", bus.we, 1);
    rstn = 1'b0;
    #1;
    check("midrst_we", bus.we, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_ready", bus.cmd_ready, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      wcnt += int'(bus.we);
    end
    check("post_rst_writes", wcnt, 0);
    run_cmd(5, 5, 7, 7, 12'hF00, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
